mux_2x1_arbiter: RTL and testbench
==================================

Name: mux_2x1_arbiter

Overview:
- Round-robin arbiter that drives the select line of the downstream 2x1 dataflow multiplexer.
- Two requesters (A, B) compete for the shared mux output. The block issues a registered one-hot grant and a matching select.
- A grant lasts until the requester drops its request, or until MAX_HOLD cycles elapse while the other side is waiting.
- Gives the purely combinational mux a fair, glitch-free, clocked select source.

Parameters:
MAX_HOLD, 4, max consecutive granted cycles while the other channel is requesting; legal range 1..2**HOLD_W
HOLD_W, 3, width of internal hold counter

Ports:
clk  input  1  rising-edge clock
reset_b  input  1  asynchronous active-low reset
req_a  input  1  request from channel A (level, held until served/done)
req_b  input  1  request from channel B
gnt_a  output  1  registered grant to A
gnt_b  output  1  registered grant to B
select  output  1  registered mux select; 1 routes A, 0 routes B
busy  output  1  high whenever gnt_a or gnt_b is high

Behaviour:
- Reset (reset_b=0, asynchronous): state=IDLE, gnt_a=0, gnt_b=0, select=0, busy=0, hold_cnt=0, last=B (A wins the first tie). Release is synchronous to clk.
- Outputs are registered; the state is decoded from registers; no combinational path exists from req to outputs.
- Latency: a request sampled high at edge N in IDLE produces its grant after edge N (visible in cycle N+1).
- IDLE:
  - req_a&req_b -> grant the channel not equal to last.
  - Only req_a -> GNT_A. Only req_b -> GNT_B. Neither -> stay IDLE.
- GNT_A (gnt_a=1, select=1), GNT_B symmetric (gnt_b=1, select=0):
  - hold_cnt increments each granted cycle; it is cleared on entry to a grant state.
  - Own req low -> release. If the other req is high, go directly to the other grant state (no IDLE bubble); else go to IDLE.
  - Own req high, other req high, hold_cnt==MAX_HOLD-1 -> forced switch to the other grant state.
  - Own req high, other req low -> stay granted; hold_cnt saturates at MAX_HOLD-1. If the other channel requests while saturated, the switch occurs at the next edge.
- last is updated to the granted channel on every grant entry.
- select holds its last value in IDLE, so the mux output does not toggle while idle.
- gnt_a and gnt_b are never high together; grant switches take exactly one edge.
- A requester dropping and raising its request in IDLE is not penalised; fairness comes only from last.
- Reset asserted mid-grant: outputs clear immediately, without waiting for clk.

Optional Feature:
- Macro: MUX_ARB_GRANT_CNT_EN.
- Defined:
  - Adds output ports gnt_cnt_a and gnt_cnt_b, each 8 bits.
  - Each counts grant-entry events for its channel and saturates at 255.
  - Both clear on reset.
  - A held grant counts once.
- Undefined: the ports and counters are absent; the arbitration behaviour is identical.

Test Plan:
- Reset mid-grant: hold req_a=1 for 3 cycles, then pulse reset_b=0 between edges -> gnt_a=0, select=0, busy=0 immediately; first grant after release goes to A.
- Single requester: req_a=1 from cycle 0 for 10 cycles, req_b=0 -> gnt_a=1, select=1 from cycle 1 through cycle 10. There is no forced switch; after req_a drops, IDLE is reached and select stays 1.
- Tie after reset: req_a=req_b=1 held, MAX_HOLD=4 -> grants alternate A×4, B×4, A×4. select toggles exactly at the switch edges; there is no cycle with both grants high and no idle cycle.
- Early release handoff: GNT_A active, req_b=1, req_a drops after 2 cycles -> gnt_b=1 on the next edge and gnt_a=0 on the same edge.
- Round-robin tie in IDLE: B was last served, both requests rise together -> A granted; repeat with A last served -> B granted.
- With MUX_ARB_GRANT_CNT_EN defined: run 300 alternating single-cycle requests -> both counters saturate at 255. Without the macro, the same bench compiles with the counter checks excluded.

Source files
------------

// File: rtl/mux_2x1_arbiter.sv
// Two-way round-robin arbiter producing a registered one-hot grant and mux select.
// Latency: request sampled at edge N yields grant in cycle N+1; grant handoffs take one edge.
// Backpressure: requests are levels held until served; optional MUX_ARB_GRANT_CNT_EN adds grant counters.
module mux_2x1_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 3
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       req_a,
  input  logic       req_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       select,
  output logic       busy
`ifdef MUX_ARB_GRANT_CNT_EN
  ,
  output logic [7:0] gnt_cnt_a,
  output logic [7:0] gnt_cnt_b
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  // Hold count value at which a contended grant must be handed over.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              last_a_q, last_a_d;  // 1: A was granted most recently
  logic              enter_a, enter_b;

  // Next-state selection: round-robin tie break in IDLE, release or forced handoff while granted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) state_d = last_a_q ? GNT_B : GNT_A;
        else if (req_a)     state_d = GNT_A;
        else if (req_b)     state_d = GNT_B;
      end
      GNT_A: begin
        if (!req_a)                            state_d = req_b ? GNT_B : IDLE;
        else if (req_b && hold_cnt_q == HOLD_LAST) state_d = GNT_B;
      end
      GNT_B: begin
        if (!req_b)                            state_d = req_a ? GNT_A : IDLE;
        else if (req_a && hold_cnt_q == HOLD_LAST) state_d = GNT_A;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant-entry detection, hold counter and round-robin history updates.
  always_comb begin
    enter_a    = (state_d == GNT_A) && (state_q != GNT_A);
    enter_b    = (state_d == GNT_B) && (state_q != GNT_B);
    hold_cnt_d = hold_cnt_q;
    last_a_d   = last_a_q;
    if (enter_a || enter_b) begin
      hold_cnt_d = '0;
    end else if (state_d == IDLE) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HOLD_LAST) begin
      // Saturate so an uncontended holder can be displaced one edge after the other side asks.
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end
    if (enter_a) last_a_d = 1'b1;
    if (enter_b) last_a_d = 1'b0;
  end

  // State, history and registered outputs; select keeps its value while idle.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      last_a_q   <= 1'b0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      select     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_a_q   <= last_a_d;
      gnt_a      <= (state_d == GNT_A);
      gnt_b      <= (state_d == GNT_B);
      busy       <= (state_d != IDLE);
      if (state_d == GNT_A)      select <= 1'b1;
      else if (state_d == GNT_B) select <= 1'b0;
    end
  end

`ifdef MUX_ARB_GRANT_CNT_EN
  logic [7:0] gnt_cnt_a_q, gnt_cnt_b_q;

  // Saturating per-channel count of grant entries; a held grant counts once.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      gnt_cnt_a_q <= 8'd0;
      gnt_cnt_b_q <= 8'd0;
    end else begin
      if (enter_a && gnt_cnt_a_q != 8'hFF) gnt_cnt_a_q <= gnt_cnt_a_q + 8'd1;
      if (enter_b && gnt_cnt_b_q != 8'hFF) gnt_cnt_b_q <= gnt_cnt_b_q + 8'd1;
    end
  end

  assign gnt_cnt_a = gnt_cnt_a_q;
  assign gnt_cnt_b = gnt_cnt_b_q;
`endif

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Testbench for mux_2x1_arbiter: vector table, corner-case sequences, random run vs. reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; requests are driven directly as levels.
module tb_mux_2x1_arbiter;

  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  logic req_a = 1'b0;
  logic req_b = 1'b0;
  logic gnt_a, gnt_b, select, busy;
`ifdef MUX_ARB_GRANT_CNT_EN
  logic [7:0] gnt_cnt_a, gnt_cnt_b;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_2x1_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(3)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .req_a   (req_a),
    .req_b   (req_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .select  (select),
    .busy    (busy)
`ifdef MUX_ARB_GRANT_CNT_EN
    ,
    .gnt_cnt_a (gnt_cnt_a),
    .gnt_cnt_b (gnt_cnt_b)
`endif
  );

  typedef struct {
    logic a;
    logic b;
    logic ga;
    logic gb;
    logic sel;
  } vec_t;

  vec_t vecs[28];

  // Reference model: who owns the mux, how many cycles it has been served, who went last.
  int m_owner;      // 0 nobody, 1 A, 2 B
  int m_served;
  bit m_last_a;
  bit m_sel;
  int m_cnt_a, m_cnt_b;

  function automatic void model_reset();
    m_owner  = 0;
    m_served = 0;
    m_last_a = 1'b0;
    m_sel    = 1'b0;
    m_cnt_a  = 0;
    m_cnt_b  = 0;
  endfunction

  function automatic void model_grant(int who);
    m_owner  = who;
    m_served = 1;
    m_last_a = (who == 1);
    if (who == 1) m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
    else          m_cnt_b = (m_cnt_b < 255) ? m_cnt_b + 1 : 255;
  endfunction

  function automatic void model_step(bit a, bit b);
    bit own, oth;
    if (m_owner == 0) begin
      if (a && b)  model_grant(m_last_a ? 2 : 1);
      else if (a)  model_grant(1);
      else if (b)  model_grant(2);
    end else begin
      own = (m_owner == 1) ? a : b;
      oth = (m_owner == 1) ? b : a;
      if (!own) begin
        if (oth) model_grant(3 - m_owner);
        else     m_owner = 0;
      end else if (oth && m_served >= MAX_HOLD) begin
        model_grant(3 - m_owner);
      end else begin
        m_served++;
      end
    end
    if (m_owner == 1)      m_sel = 1'b1;
    else if (m_owner == 2) m_sel = 1'b0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    req_a   = 1'b0;
    req_b   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset gnt_a", gnt_a, 0);
    check("reset gnt_b", gnt_b, 0);
    check("reset select", select, 0);
    check("reset busy", busy, 0);
    reset_b = 1'b1;
    model_reset();
  endtask

  function automatic vec_t mk(logic a, logic b, logic ga, logic gb, logic sel);
    vec_t v;
    v.a = a; v.b = b; v.ga = ga; v.gb = gb; v.sel = sel;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Tie from reset alternates 4/4/4, then idle, RR tie breaks, early handoff, saturated switch.
    for (int i = 0; i < 4; i++)  vecs[i] = mk(1, 1, 1, 0, 1);
    for (int i = 4; i < 8; i++)  vecs[i] = mk(1, 1, 0, 1, 0);
    for (int i = 8; i < 12; i++) vecs[i] = mk(1, 1, 1, 0, 1);
    vecs[12] = mk(0, 0, 0, 0, 1);
    vecs[13] = mk(0, 0, 0, 0, 1);
    vecs[14] = mk(1, 1, 0, 1, 0);
    vecs[15] = mk(0, 0, 0, 0, 0);
    vecs[16] = mk(1, 1, 1, 0, 1);
    vecs[17] = mk(1, 0, 1, 0, 1);
    vecs[18] = mk(0, 1, 0, 1, 0);
    vecs[19] = mk(0, 0, 0, 0, 0);
    for (int i = 20; i < 26; i++) vecs[i] = mk(1, 0, 1, 0, 1);
    vecs[26] = mk(1, 1, 0, 1, 0);
    vecs[27] = mk(0, 0, 0, 0, 0);

    model_reset();
    do_reset();

    for (int i = 0; i < 28; i++) begin
      req_a = vecs[i].a;
      req_b = vecs[i].b;
      step();
      check($sformatf("vec%0d gnt_a", i), gnt_a, vecs[i].ga);
      check($sformatf("vec%0d gnt_b", i), gnt_b, vecs[i].gb);
      check($sformatf("vec%0d select", i), select, vecs[i].sel);
      check($sformatf("vec%0d busy", i), busy, vecs[i].ga | vecs[i].gb);
    end

    // Single requester holds indefinitely; select stays at A once idle.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      req_a = 1'b1;
      req_b = 1'b0;
      step();
      check($sformatf("single c%0d gnt_a", i), gnt_a, 1);
      check($sformatf("single c%0d select", i), select, 1);
    end
    req_a = 1'b0;
    step();
    check("single release busy", busy, 0);
    step();
    check("single idle select", select, 1);

    // Reset pulsed between edges while A is granted.
    do_reset();
    req_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("pre-reset c%0d gnt_a", i), gnt_a, 1);
    end
    #3 reset_b = 1'b0;
    #1;
    check("midreset gnt_a", gnt_a, 0);
    check("midreset select", select, 0);
    check("midreset busy", busy, 0);
    #2 reset_b = 1'b1;
    req_a = 1'b1;
    req_b = 1'b1;
    step();
    check("post-reset tie gnt_a", gnt_a, 1);
    check("post-reset tie gnt_b", gnt_b, 0);

`ifdef MUX_ARB_GRANT_CNT_EN
    // Alternating single-cycle requests: every cycle is a new grant entry.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      req_a = 1'b1; req_b = 1'b0;
      step();
      req_a = 1'b0; req_b = 1'b1;
      step();
      if (i == 9) begin
        check("cnt_a after 10", gnt_cnt_a, 10);
        check("cnt_b after 10", gnt_cnt_b, 10);
      end
    end
    check("cnt_a saturated", gnt_cnt_a, 255);
    check("cnt_b saturated", gnt_cnt_b, 255);
`endif

    // Sticky random requests against the reference model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req_a = ~req_a;
      if ($urandom_range(0, 3) == 0) req_b = ~req_b;
      model_step(req_a, req_b);
      step();
      check($sformatf("rnd%0d gnt_a", i), gnt_a, (m_owner == 1));
      check($sformatf("rnd%0d gnt_b", i), gnt_b, (m_owner == 2));
      check($sformatf("rnd%0d select", i), select, m_sel);
      check($sformatf("rnd%0d busy", i), busy, (m_owner != 0));
      check($sformatf("rnd%0d onehot", i), gnt_a & gnt_b, 0);
`ifdef MUX_ARB_GRANT_CNT_EN
      check($sformatf("rnd%0d cnt_a", i), gnt_cnt_a, m_cnt_a);
      check($sformatf("rnd%0d cnt_b", i), gnt_cnt_b, m_cnt_b);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
